// File: rtl/bp_feedback.sv
// bp_feedback: in-order branch outcome tracker producing predictor training updates
module bp_feedback #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_ce,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_pred,
  output logic [ID_W-1:0]  alloc_id,
  output logic             full,
  input  logic             res_ce,
  input  logic [ID_W-1:0]  res_id,
  input  logic             res_taken,
  input  logic             commit_ce,
  output logic             head_ready,
  input  logic             flush,
  output logic [ID_W:0]    count,
  output logic             out_bp_ce,
  output logic [TAG_W-1:0] out_bp_tag,
  output logic             out_bp_jump,
  output logic             mispredict
);
  logic [DEPTH-1:0] valid_q, resolved_q, pred_q, taken_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [ID_W-1:0]  head_q, tail_q;
  logic [ID_W:0]    count_q, count_d;
  logic             do_alloc, do_commit;

  assign full       = count_q == (ID_W+1)'(DEPTH);
  assign head_ready = valid_q[head_q] & resolved_q[head_q];
  assign alloc_id   = tail_q;
  assign count      = count_q;
  assign do_alloc   = alloc_ce & ~full;
  assign do_commit  = commit_ce & head_ready;

  // Occupancy moves only when alloc and commit are not both accepted
  always_comb count_d = count_q + (ID_W+1)'(do_alloc) - (ID_W+1)'(do_commit);

  // Record, resolve and retire entries; flush wins over everything else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      resolved_q  <= '0;
      pred_q      <= '0;
      taken_q     <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_bp_ce   <= 1'b0;
      out_bp_tag  <= '0;
      out_bp_jump <= 1'b0;
      mispredict  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        valid_q    <= '0;
        resolved_q <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        out_bp_ce  <= 1'b0;
        mispredict <= 1'b0;
      end else begin
        if (res_ce && valid_q[res_id]) begin
          resolved_q[res_id] <= 1'b1;
          taken_q[res_id]    <= res_taken;
        end
        if (do_alloc) begin
          valid_q[tail_q]    <= 1'b1;
          resolved_q[tail_q] <= 1'b0;
          tag_q[tail_q]      <= alloc_tag;
          pred_q[tail_q]     <= alloc_pred;
          tail_q             <= tail_q + 1'b1;
        end
        if (do_commit) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
          out_bp_tag      <= tag_q[head_q];
          out_bp_jump     <= taken_q[head_q];
        end
        out_bp_ce  <= do_commit;
        mispredict <= do_commit & (taken_q[head_q] ^ pred_q[head_q]);
        count_q    <= count_d;
      end
    end
  end
endmodule

// File: tb/tb_bp_feedback.sv
// tb_bp_feedback: directed and random checks of bp_feedback against a queue model
module tb_bp_feedback;
  logic       clk = 1'b0;
  logic       rst, rdy, alloc_ce, alloc_pred, res_ce, res_taken, commit_ce, flush;
  logic [7:0] alloc_tag, out_bp_tag;
  logic [2:0] res_id, alloc_id;
  logic [3:0] count;
  logic       full, head_ready, out_bp_ce, out_bp_jump, mispredict;

  bp_feedback dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_ce(alloc_ce), .alloc_tag(alloc_tag), .alloc_pred(alloc_pred),
    .alloc_id(alloc_id), .full(full),
    .res_ce(res_ce), .res_id(res_id), .res_taken(res_taken),
    .commit_ce(commit_ce), .head_ready(head_ready), .flush(flush), .count(count),
    .out_bp_ce(out_bp_ce), .out_bp_tag(out_bp_tag), .out_bp_jump(out_bp_jump),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tag;
    logic       pred;
    logic       res;
    logic       tk;
    int         id;
  } rec_t;

  rec_t       q[$];
  int         tl;
  logic       e_ce, e_jump, e_mis;
  logic [7:0] e_tag;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic check_all(input string n);
    chk({n, ".count"}, 32'(count), 32'(q.size()));
    chk({n, ".full"}, 32'(full), 32'(q.size() == 8));
    chk({n, ".head_ready"}, 32'(head_ready), 32'(q.size() > 0 && q[0].res));
    chk({n, ".alloc_id"}, 32'(alloc_id), 32'(tl));
    chk({n, ".out_bp_ce"}, 32'(out_bp_ce), 32'(e_ce));
    chk({n, ".mispredict"}, 32'(mispredict), 32'(e_mis));
    chk({n, ".tag"}, 32'(out_bp_tag), 32'(e_tag));
    chk({n, ".jump"}, 32'(out_bp_jump), 32'(e_jump));
  endtask

  task automatic model_reset();
    q.delete();
    tl = 0;
    e_ce = 0; e_jump = 0; e_mis = 0; e_tag = 0;
  endtask

  task automatic step(input string n, input logic a, input logic [7:0] t, input logic p,
                      input logic r, input logic [2:0] rid, input logic rt,
                      input logic c, input logic f);
    bit   was_full, hr;
    rec_t cr;
    alloc_ce = a; alloc_tag = t; alloc_pred = p;
    res_ce = r; res_id = rid; res_taken = rt;
    commit_ce = c; flush = f;
    was_full = q.size() == 8;
    hr = q.size() > 0 && q[0].res;
    if (rdy) begin
      if (f) begin
        q.delete();
        tl = 0; e_ce = 0; e_mis = 0;
      end else begin
        e_ce = c && hr;
        e_mis = 0;
        if (e_ce) begin
          cr = q.pop_front();
          e_tag = cr.tag; e_jump = cr.tk; e_mis = cr.tk != cr.pred;
        end
        if (r) foreach (q[i]) if (q[i].id == int'(rid)) begin q[i].res = 1; q[i].tk = rt; end
        if (a && !was_full) begin
          q.push_back('{tag: t, pred: p, res: 1'b0, tk: 1'b0, id: tl});
          tl = (tl + 1) % 8;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(n);
  endtask

  initial begin
    rst = 0; rdy = 1;
    alloc_ce = 0; alloc_tag = 0; alloc_pred = 0;
    res_ce = 0; res_id = 0; res_taken = 0; commit_ce = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    step("basic_alloc", 1, 8'h12, 1, 0, 0, 0, 0, 0);
    step("basic_res",   0, 0, 0, 1, 0, 0, 0, 0);
    step("basic_commit",0, 0, 0, 0, 0, 0, 1, 0);
    step("basic_idle",  0, 0, 0, 0, 0, 0, 0, 0);

    step("ooo_flush", 0, 0, 0, 0, 0, 0, 0, 1);
    step("ooo_a0", 1, 8'hA0, 0, 0, 0, 0, 0, 0);
    step("ooo_a1", 1, 8'hA1, 1, 0, 0, 0, 0, 0);
    step("ooo_a2", 1, 8'hA2, 1, 0, 0, 0, 0, 0);
    step("ooo_r2", 0, 0, 0, 1, 2, 0, 0, 0);
    step("ooo_r0", 0, 0, 0, 1, 0, 1, 0, 0);
    step("ooo_c0", 0, 0, 0, 0, 0, 0, 1, 0);
    step("ooo_c_ign", 0, 0, 0, 0, 0, 0, 1, 0);
    step("ooo_r1", 0, 0, 0, 1, 1, 1, 0, 0);
    step("ooo_c1", 0, 0, 0, 0, 0, 0, 1, 0);
    step("ooo_c2", 0, 0, 0, 0, 0, 0, 1, 0);

    step("full_flush", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("full_alloc", 1, 8'(8'h30 + i), 8'(i) % 2 == 1, 0, 0, 0, 0, 0);
    step("full_9th", 1, 8'hFF, 1, 0, 0, 0, 0, 0);
    step("full_r0", 0, 0, 0, 1, 0, 1, 0, 0);
    step("full_ac", 1, 8'hEE, 0, 0, 0, 0, 1, 0);
    step("wrap_alloc", 1, 8'h77, 0, 0, 0, 0, 0, 0);
    step("wrap_full", 1, 8'h66, 0, 0, 0, 0, 0, 0);

    step("sim_flush", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("sim_alloc", 1, 8'(8'h50 + i), 0, 0, 0, 0, 0, 0);
    step("sim_r0", 0, 0, 0, 1, 0, 0, 0, 0);
    step("sim_ac", 1, 8'h53, 1, 0, 0, 0, 1, 0);

    step("fl_r1", 0, 0, 0, 1, 1, 1, 0, 0);
    step("fl_all", 1, 8'h99, 1, 1, 2, 1, 1, 1);

    step("rdy_alloc", 1, 8'hC3, 0, 0, 0, 0, 0, 0);
    step("rdy_res", 0, 0, 0, 1, 0, 1, 0, 0);
    step("rdy_commit", 1, 8'hC4, 1, 0, 0, 0, 1, 0);
    rdy = 0;
    for (int i = 0; i < 3; i++) step("rdy_hold", 1, 8'(i), 1, 1, 0, 0, 1, 1);
    rdy = 1;
    step("rdy_back", 0, 0, 0, 0, 0, 0, 0, 0);

    step("ar_alloc", 1, 8'hD1, 1, 0, 0, 0, 0, 0);
    step("ar_res", 0, 0, 0, 1, 1, 1, 0, 0);
    step("ar_commit", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("ar_pulse_pre", 32'(out_bp_ce), 32'd1);
    #3;
    rst = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1;

    for (int k = 0; k < 400; k++) begin
      rdy = $urandom_range(0, 9) != 0;
      step("rand", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    rdy = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
